// File: rtl/lcd_ddram_reader.sv
// rtl/lcd_ddram_reader.sv - HD44780 16x2 DDRAM read-back sequencer (32-char index/data/valid stream)
// Optional LCD_READER_BUSY_POLL_EN replaces each fixed T_EXEC wait with busy-flag polling.
module lcd_ddram_reader #(
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 16,
  parameter int T_HOLD  = 16,
  parameter int T_EXEC  = 1200
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  output logic       oBUSY,
  output logic       oDONE,
  output logic [4:0] oCHAR_INDEX,
  output logic [7:0] oCHAR_DATA,
  output logic       oCHAR_VALID,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  localparam int CW = 16;

  typedef enum logic [3:0] {
    IDLE, CMD_SETUP, CMD_EHIGH, CMD_HOLD, CMD_WAIT,
    RD_SETUP, RD_EHIGH, RD_HOLD, RD_WAIT,
    POLL_SETUP, POLL_EHIGH, POLL_HOLD, DONE
  } state_t;

`ifdef LCD_READER_BUSY_POLL_EN
  localparam state_t CMD_NEXT = POLL_SETUP;
  localparam state_t RD_NEXT  = POLL_SETUP;
  logic poll_rd;
  logic bf;
`else
  localparam state_t CMD_NEXT = CMD_WAIT;
  localparam state_t RD_NEXT  = RD_WAIT;
`endif

  state_t        state, nxt, after_rd;
  logic [CW-1:0] cnt;
  logic [4:0]    idx;
  logic          drive;
  logic          last;
  logic          rd_wait_done;

  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      CMD_SETUP, RD_SETUP, POLL_SETUP: phase_len = CW'(T_SETUP - 1);
      CMD_EHIGH, RD_EHIGH, POLL_EHIGH: phase_len = CW'(T_EHIGH - 1);
      CMD_HOLD,  RD_HOLD,  POLL_HOLD:  phase_len = CW'(T_HOLD - 1);
      CMD_WAIT,  RD_WAIT:              phase_len = CW'(T_EXEC - 1);
      default:                         phase_len = '0;
    endcase
  endfunction

  // Set-DDRAM-Address: 0x80 for line 1, 0xC0 for line 2
  assign LCD_DATA = drive ? {1'b1, idx[4], 2'b00, idx[3:0]} : 8'hzz;
  assign last     = (cnt == '0);
  assign after_rd = (idx == 5'd31) ? DONE : (idx == 5'd15) ? CMD_SETUP : RD_SETUP;

`ifdef LCD_READER_BUSY_POLL_EN
  assign rd_wait_done = (state == POLL_HOLD) && last && !bf && poll_rd;
`else
  assign rd_wait_done = (state == RD_WAIT) && last;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:       if (iSTART) nxt = CMD_SETUP;
      CMD_SETUP:  if (last) nxt = CMD_EHIGH;
      CMD_EHIGH:  if (last) nxt = CMD_HOLD;
      CMD_HOLD:   if (last) nxt = CMD_NEXT;
      CMD_WAIT:   if (last) nxt = RD_SETUP;
      RD_SETUP:   if (last) nxt = RD_EHIGH;
      RD_EHIGH:   if (last) nxt = RD_HOLD;
      RD_HOLD:    if (last) nxt = RD_NEXT;
      RD_WAIT:    if (last) nxt = after_rd;
`ifdef LCD_READER_BUSY_POLL_EN
      POLL_SETUP: if (last) nxt = POLL_EHIGH;
      POLL_EHIGH: if (last) nxt = POLL_HOLD;
      POLL_HOLD:  if (last) nxt = bf ? POLL_SETUP : (poll_rd ? after_rd : RD_SETUP);
`endif
      DONE:       nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      drive       <= 1'b0;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
      oCHAR_INDEX <= '0;
      oCHAR_DATA  <= '0;
      oCHAR_VALID <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_E       <= 1'b0;
      LCD_RS      <= 1'b0;
`ifdef LCD_READER_BUSY_POLL_EN
      poll_rd     <= 1'b0;
      bf          <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= phase_len(nxt);
      else if (!last)   cnt <= cnt - CW'(1);

      if (state == IDLE && iSTART)          idx <= '0;
      else if (rd_wait_done && idx != 5'd31) idx <= idx + 5'd1;

      oCHAR_VALID <= (state == RD_EHIGH) && last;
      if (state == RD_EHIGH && last) begin
        oCHAR_DATA  <= LCD_DATA;
        oCHAR_INDEX <= idx;
      end

`ifdef LCD_READER_BUSY_POLL_EN
      if (state == CMD_HOLD) poll_rd <= 1'b0;
      if (state == RD_HOLD)  poll_rd <= 1'b1;
      if (state == POLL_EHIGH && last) bf <= LCD_DATA[7];
`endif

      // Bus outputs are decoded from the next state so they change with E low
      oBUSY  <= (nxt != IDLE);
      oDONE  <= (nxt == DONE);
      LCD_E  <= nxt inside {CMD_EHIGH, RD_EHIGH, POLL_EHIGH};
      LCD_RS <= nxt inside {RD_SETUP, RD_EHIGH, RD_HOLD, RD_WAIT};
      LCD_RW <= nxt inside {RD_SETUP, RD_EHIGH, RD_HOLD, RD_WAIT, POLL_SETUP, POLL_EHIGH, POLL_HOLD};
      drive  <= nxt inside {CMD_SETUP, CMD_EHIGH, CMD_HOLD, CMD_WAIT};
    end
  end

endmodule

// File: tb/tb_lcd_ddram_reader.sv
// tb/tb_lcd_ddram_reader.sv - self-checking bench for lcd_ddram_reader with an HD44780 DDRAM read model
module tb_lcd_ddram_reader;
  localparam int TS = 1, TE = 2, TH = 2, TX = 4;
`ifdef LCD_READER_BUSY_POLL_EN
  localparam int WAIT_CYC      = 4 * (TS + TE + TH);
  localparam int POLLS_PER_RUN = 4 * 34;
`else
  localparam int WAIT_CYC      = TX;
  localparam int POLLS_PER_RUN = 0;
`endif
  localparam int FIRST_LAT = 2 * TS + 2 * TE + TH + WAIT_CYC + 1;
  localparam int RUN_LIMIT = 20000;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, valid, rw, e, rs;
  logic [4:0] cidx;
  logic [7:0] cdata;
  wire  [7:0] lcd_data;

  int checks = 0, errors = 0;
  int exp_idx = 0, strobes = 0, dones = 0, cmd_pulses = 0, poll_pulses = 0;
  logic [7:0] cmd_vals [$];
  logic [7:0] got [0:31];
  logic [7:0] ddram [0:127];
  logic [6:0] ac = 7'd0;
  int busy_left = 0;
  logic e_prev = 1'b0, rs_prev = 1'b0, rw_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_ddram_reader #(.T_SETUP(TS), .T_EHIGH(TE), .T_HOLD(TH), .T_EXEC(TX)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start),
    .oBUSY(busy), .oDONE(done),
    .oCHAR_INDEX(cidx), .oCHAR_DATA(cdata), .oCHAR_VALID(valid),
    .LCD_DATA(lcd_data), .LCD_RW(rw), .LCD_E(e), .LCD_RS(rs)
  );

  // LCD model: address counter, auto-increment on data reads, busy flag for 3 polls after each access
  assign lcd_data = rw ? (rs ? ddram[ac] : {busy_left != 0, ac}) : 8'hzz;

  always @(negedge e) begin
    if (!rs && !rw) begin
      if (lcd_data[7] === 1'b1) ac = lcd_data[6:0];
      busy_left = 3;
    end else if (rs && rw) begin
      ac = ac + 7'd1;
      busy_left = 3;
    end else if (!rs && rw && busy_left > 0) begin
      busy_left--;
    end
  end

  function automatic logic [7:0] exp_char(input int i);
    logic [6:0] a;
    a = (i < 16) ? 7'(i) : 7'(i + 48);
    return ddram[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      chk("char_index", 32'(cidx), 32'(exp_idx));
      chk("char_data", 32'(cdata), 32'(exp_char(exp_idx)));
      chk("strobe_in_data_read", 32'({rs, rw}), 32'd3);
      got[cidx] = cdata;
      exp_idx++;
      strobes++;
    end
    if (done) dones++;
    if (e && !e_prev) begin
      if (!rs && !rw) begin
        cmd_pulses++;
        cmd_vals.push_back(lcd_data);
      end
      if (!rs && rw) poll_pulses++;
    end
    if (e && e_prev) chk("rs_rw_stable_while_e", 32'({rs, rw}), 32'({rs_prev, rw_prev}));
    if (!busy) chk("idle_lines", 32'({e, rw, rs}), 32'd0);
    e_prev  = e;
    rs_prev = rs;
    rw_prev = rw;
  end

  // mode 0: plain run, 1: extra iSTART around idx 5, 2: iSTART in the DONE cycle
  task automatic run_screen(input int mode);
    int n;
    bit poked;
    exp_idx = 0; strobes = 0; dones = 0; cmd_pulses = 0; poll_pulses = 0;
    cmd_vals.delete();
    poked = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    n = 1;
    while (!valid && n < RUN_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("first_strobe_latency", n, FIRST_LAT);
    n = 0;
    while (!done && n < RUN_LIMIT) begin
      if (mode == 1 && !poked && strobes == 5) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_reached", 32'(done), 32'd1);
    chk("busy_during_done", 32'(busy), 32'd1);
    if (mode == 2) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 32'({busy, done}), 32'd0);
    repeat (30) @(negedge clk);
    chk("busy_stays_low", 32'(busy), 32'd0);
    chk("strobe_count", strobes, 32);
    chk("done_count", dones, 1);
    chk("cmd_pulse_count", cmd_pulses, 2);
    chk("cmd_addr_line1", (cmd_vals.size() > 0) ? 32'(cmd_vals[0]) : 32'hFFFF_FFFF, 32'h80);
    chk("cmd_addr_line2", (cmd_vals.size() > 1) ? 32'(cmd_vals[1]) : 32'hFFFF_FFFF, 32'hC0);
    chk("poll_pulse_count", poll_pulses, POLLS_PER_RUN);
  endtask

  initial begin
    string l1, l2;
    int n;
    l1 = "HELLO WORLD 0123";
    l2 = "abcdefghijklmnop";
    for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
    for (int i = 0; i < 16; i++) begin
      ddram[i]      = l1[i];
      ddram[64 + i] = l2[i];
    end

    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_flags", 32'({busy, done, valid, e, rw, rs}), 32'd0);
    chk("reset_index", 32'(cidx), 32'd0);
    chk("reset_data", 32'(cdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_screen(0);
    chk("char0_H", 32'(got[0]), 32'h48);
    chk("char15_3", 32'(got[15]), 32'h33);
    chk("char16_a", 32'(got[16]), 32'h61);
    chk("char31_p", 32'(got[31]), 32'h70);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom_range(255));
      repeat ($urandom_range(20, 1)) @(negedge clk);
      run_screen(r % 3);
    end

    // asynchronous reset while E is high on character 20
    exp_idx = 0; strobes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(strobes >= 20 && e && rs) && n < RUN_LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("reached_idx20_e_high", 32'({e, rs}), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_reset_lines", 32'({busy, done, valid, e, rw, rs}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_strobe_after_reset", strobes, 20);
    chk("idle_after_reset", 32'(busy), 32'd0);

    for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom_range(255));
    run_screen(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
